// File: rtl/gather_pkg.sv
// gather_pkg: shared types and helpers for the narrow-to-wide word gatherer.
package gather_pkg;

    typedef enum logic {ACC, WAIT} state_t;

    function automatic int beats_for(input int in_w, input int out_w);
        return (out_w + in_w - 1) / in_w;
    endfunction

    // LSB position of a beat slot inside the raw packed word.
    function automatic int slot_lsb(input int pack_w, input int in_w, input int slot, input bit msb_first);
        return msb_first ? pack_w - (slot + 1) * in_w : slot * in_w;
    endfunction

endpackage

// File: rtl/out_slot.sv
// out_slot: one-entry valid/ready register slice holding a packed word and its beat count.
module out_slot #(
    parameter int W  = 43,
    parameter int BW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [W-1:0]  i_data,
    input  logic [BW-1:0] i_beats,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [W-1:0]  o_data,
    output logic [BW-1:0] o_beats
);

    logic          r_valid;
    logic [W-1:0]  r_data;
    logic [BW-1:0] r_beats;

    // Data and count only change on load, so they hold after a drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_beats <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_beats <= i_beats;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_beats = r_beats;

endmodule

// File: rtl/word_gather_pack.sv
// word_gather_pack: gathers BEATS narrow beats into one packed word, with backpressure
// on both sides, overlapped collection/draining and a zero-padded partial flush.
module word_gather_pack
    import gather_pkg::*;
#(
    parameter  int IN_W      = 12,
    parameter  int OUT_W     = 43,
    parameter  int MSB_FIRST = 1,
    localparam int BEATS     = beats_for(IN_W, OUT_W),
    localparam int PACK_W    = BEATS * IN_W,
    localparam int CNT_W     = $clog2(BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_beats,
    input  logic             out_ready
);

    if (OUT_W < IN_W || IN_W < 1) begin : g_bad_params
        $error("word_gather_pack: need IN_W >= 1 and OUT_W >= IN_W");
    end

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_ins, w_cnt_nxt;
    logic [PACK_W-1:0]   r_acc, w_acc_ins, w_acc_nxt;
    logic                w_accept, w_close, w_slot_free, w_load;

    assign in_ready    = (r_state == ACC);
    assign w_accept    = in_valid && in_ready;
    assign w_slot_free = !out_valid || out_ready;
    assign w_cnt_ins   = r_cnt + CNT_W'(w_accept);
    assign w_close     = (w_accept && r_cnt == CNT_W'(BEATS - 1)) || (flush && (r_cnt != '0 || w_accept));

    always_comb begin
        w_acc_ins = r_acc;
        for (int s = 0; s < BEATS; s++)
            if (w_accept && r_cnt == CNT_W'(s))
                w_acc_ins[slot_lsb(PACK_W, IN_W, s, MSB_FIRST != 0) +: IN_W] = in_data;
    end

    // In WAIT nothing is accepted, so w_acc_ins/w_cnt_ins equal the held word.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (r_state == ACC) begin
            w_load      = w_close && w_slot_free;
            w_state_nxt = (w_close && !w_slot_free) ? WAIT : ACC;
        end else begin
            w_load      = w_slot_free;
            w_state_nxt = w_slot_free ? ACC : WAIT;
        end
        w_acc_nxt = w_load ? '0 : w_acc_ins;
        w_cnt_nxt = w_load ? '0 : w_cnt_ins;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ACC;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    out_slot #(.W(OUT_W), .BW(CNT_W)) u_out_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_acc_ins[OUT_W-1:0]),
        .i_beats (w_cnt_ins),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_beats (out_beats)
    );

endmodule

// File: tb/tb_word_gather_pack.sv
// tb_word_gather_pack: directed checks of packing order, flush, backpressure and reset.
module tb_word_gather_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush, out_ready;
    logic [11:0] in_data;
    logic        in_ready, out_valid, in_ready_l, out_valid_l;
    logic [42:0] out_data, out_data_l;
    logic [2:0]  out_beats, out_beats_l;
    int          n_pass = 0;
    int          n_total = 0;

    word_gather_pack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_beats(out_beats),
        .out_ready(out_ready)
    );

    word_gather_pack #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_l),
        .flush(flush), .out_valid(out_valid_l), .out_data(out_data_l), .out_beats(out_beats_l),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (out_data !== 43'h0) $display("FAIL rst_data got=%h exp=0", out_data); else n_pass++;
        n_total++; if (out_beats !== 3'd0) $display("FAIL rst_beats got=%0d exp=0", out_beats); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else n_pass++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_full_word();
        logic [11:0] b [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
        bit rdy_ok = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b1) rdy_ok = 1'b0;
            in_valid = 1'b1;
            in_data  = b[i];
            step();
            if (i == 2) begin
                n_total++; if (out_valid !== 1'b0) $display("FAIL early_valid got=%b exp=0", out_valid); else n_pass++;
            end
        end
        in_valid = 1'b0;
        if (in_ready !== 1'b1) rdy_ok = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL full_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (out_data !== 43'h23456789ABC) $display("FAIL full_data_msb got=%h exp=23456789abc", out_data); else n_pass++;
        n_total++; if (out_beats !== 3'd4) $display("FAIL full_beats got=%0d exp=4", out_beats); else n_pass++;
        n_total++; if (out_data_l !== 43'h3C789456123) $display("FAIL full_data_lsb got=%h exp=3c789456123", out_data_l); else n_pass++;
        n_total++; if (out_beats_l !== 3'd4) $display("FAIL full_beats_lsb got=%0d exp=4", out_beats_l); else n_pass++;
        n_total++; if (rdy_ok !== 1'b1) $display("FAIL full_in_ready_low got=%b exp=1", rdy_ok); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL drain_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (out_data !== 43'h23456789ABC) $display("FAIL drain_hold got=%h exp=23456789abc", out_data); else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send(12'h123);
        send(12'h456);
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL flush2_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (out_data !== 43'h23456000000) $display("FAIL flush2_data got=%h exp=23456000000", out_data); else n_pass++;
        n_total++; if (out_beats !== 3'd2) $display("FAIL flush2_beats got=%0d exp=2", out_beats); else n_pass++;
        n_total++; if (out_data_l !== 43'h456123) $display("FAIL flush2_data_lsb got=%h exp=456123", out_data_l); else n_pass++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_empty got=%b exp=0", out_valid); else n_pass++;
        send(12'h123);
        send(12'h456);
        flush = 1'b1;
        send(12'h789);
        flush = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL flush3_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (out_data !== 43'h23456789000) $display("FAIL flush3_data got=%h exp=23456789000", out_data); else n_pass++;
        n_total++; if (out_beats !== 3'd3) $display("FAIL flush3_beats got=%0d exp=3", out_beats); else n_pass++;
        n_total++; if (out_data_l !== 43'h789456123) $display("FAIL flush3_data_lsb got=%h exp=789456123", out_data_l); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        bit rdy_ok = 1'b1;
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (in_ready !== 1'b1) rdy_ok = 1'b0;
            send(12'(i));
        end
        n_total++; if (rdy_ok !== 1'b1) $display("FAIL bp_in_ready_early got=%b exp=1", rdy_ok); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_drop got=%b exp=0", in_ready); else n_pass++;
        n_total++; if (out_data !== 43'h1002003004) $display("FAIL bp_word1_stable got=%h exp=1002003004", out_data); else n_pass++;
        in_valid = 1'b1;
        in_data  = 12'h009;
        step();
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_off got=%b exp=0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || out_data !== 43'h1002003004) $display("FAIL bp_word1_held got=%b/%h exp=1/1002003004", out_valid, out_data); else n_pass++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL bp_no_bubble got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (out_data !== 43'h5006007008) $display("FAIL bp_word2 got=%h exp=5006007008", out_data); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_back got=%b exp=1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (out_data !== 43'h5006007008) $display("FAIL bp_word2_stable got=%h exp=5006007008", out_data); else n_pass++;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        n_total++; if (out_valid !== 1'b1 || out_data !== 43'h9000000000) $display("FAIL bp_held_beat got=%b/%h exp=1/9000000000", out_valid, out_data); else n_pass++;
        n_total++; if (out_beats !== 3'd1) $display("FAIL bp_held_beats got=%0d exp=1", out_beats); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_final_drain got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(12'h0F0 + 12'(i));
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (out_data !== 43'h0) $display("FAIL mid_rst_data got=%h exp=0", out_data); else n_pass++;
        n_total++; if (out_beats !== 3'd0) $display("FAIL mid_rst_beats got=%0d exp=0", out_beats); else n_pass++;
        #3;
        rst = 1'b1;
        step();
        out_ready = 1'b1;
        send(12'hAAA);
        send(12'hBBB);
        send(12'hCCC);
        n_total++; if (out_valid !== 1'b0) $display("FAIL post_rst_early got=%b exp=0", out_valid); else n_pass++;
        send(12'hDDD);
        n_total++; if (out_valid !== 1'b1 || out_data !== 43'h2ABBBCCCDDD) $display("FAIL post_rst_word got=%b/%h exp=1/2abbbcccddd", out_valid, out_data); else n_pass++;
        n_total++; if (out_beats !== 3'd4) $display("FAIL post_rst_beats got=%0d exp=4", out_beats); else n_pass++;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_word();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/word_gather_pack.md
Name: word_gather_pack

Overview:
- Parametrised gatherer that collects BEATS narrow words of width IN_W from an upstream FIFO and emits one packed word of width OUT_W.
- Generalises the fixed 4x12-to-43-bit memory packer with:
  - valid/ready handshakes on both sides, giving true backpressure;
  - a separate accumulator and output slot, so input collection overlaps output draining;
  - configurable beat ordering;
  - a flush that emits a partial, zero-padded word.
- Sits between the sample FIFO and wide-word consumers in the datapath.

Parameters:
- IN_W, 12, width of each input beat.
- OUT_W, 43, width of the packed output word; must satisfy OUT_W >= IN_W.
- MSB_FIRST, 1, beat ordering. 1 = first beat occupies the most-significant slot; 0 = first beat occupies the least-significant slot.
- BEATS (localparam), ceil(OUT_W/IN_W), beats per word; 4 at defaults.
- PACK_W (localparam), BEATS*IN_W, raw packed width; 48 at defaults.
- CNT_W (localparam), $clog2(BEATS+1), width of the beat counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream beat valid.
- in_data  in  IN_W  upstream beat.
- in_ready  out  1  block accepts a beat this cycle.
- flush  in  1  close the current partial word.
- out_valid  out  1  packed word valid.
- out_data  out  OUT_W  packed word.
- out_beats  out  CNT_W  number of real beats in out_data (1..BEATS).
- out_ready  in  1  downstream accepts the word.

Behaviour:
- Reset: state=ACC, cnt=0, accumulator=0, out_valid=0, out_data=0, out_beats=0. in_ready=1 (combinational from state). Reset mid-word discards all partial and pending data.
- Beat accept: in_valid && in_ready. The beat is written to slot cnt, and cnt increments.
- Slot placement:
  - MSB_FIRST=1: slot i occupies bits [PACK_W-1-i*IN_W -: IN_W].
  - MSB_FIRST=0: slot i occupies bits [i*IN_W +: IN_W].
- Output mapping: out_data = packed[OUT_W-1:0], i.e. the top PACK_W-OUT_W bits are dropped. Unfilled slots read as 0.
- slot_free = !out_valid || out_ready.
- State ACC:
  - in_ready=1.
  - Close event: a beat is accepted with cnt==BEATS-1, or flush=1 with (cnt>0 or a beat accepted this cycle). A beat accepted in the same cycle as flush is included in the word.
  - On a close event:
    - if slot_free: load the output slot at this edge (out_valid=1 next cycle, out_beats = final count), clear the accumulator, set cnt=0, stay in ACC;
    - otherwise go to WAIT, holding the accumulator and its count.
  - Latency: the closing beat at edge k produces out_valid visible in cycle k+1.
- State WAIT:
  - in_ready=0; flush is ignored.
  - When slot_free, load the output slot, clear the accumulator, set cnt=0, go to ACC. in_ready is 1 in the following cycle.
- Output slot:
  - out_valid && out_ready with no reload: out_valid=0 next cycle; out_data and out_beats hold their values.
  - A simultaneous drain and reload gives back-to-back valid words with no bubble.
  - out_data and out_beats are stable while out_valid && !out_ready.
- Flush with cnt==0 and no beat accepted: no effect, and no empty word is emitted.
- Throughput: with out_ready tied high, one word per BEATS accepted beats, with no stall cycles.
- Elaboration error if OUT_W < IN_W or IN_W < 1.

Decomposition:
- Shared package gather_pkg:
  - beats_for(in_w, out_w) function (ceiling division);
  - state enum {ACC, WAIT};
  - the slot-offset function used for MSB_FIRST/LSB placement.
- Sub-module out_slot: a one-entry valid/ready register slice (load, drain, hold). It is parametrised on data width and carries out_data and out_beats together.

Test Plan:
- Defaults, out_ready=1: feed beats 0x123, 0x456, 0x789, 0xABC on consecutive cycles. Expect out_valid high one cycle after the 4th beat, out_data=43'h23456789ABC, out_beats=4, and in_ready never low.
- MSB_FIRST=0, same beats: expect out_data=43'h3C789456123, out_beats=4.
- Partial word: feed 0x123, 0x456, then flush=1 alone. Expect out_data=43'h23456000000, out_beats=2. A flush with cnt==0 produces no word. Flush in the same cycle as a 3rd beat 0x789 gives out_beats=3 and out_data=43'h23456789000.
- Backpressure, out_ready=0: stream 8 beats.
  - Word 1 held stable.
  - in_ready drops the cycle after the 8th beat.
  - A 9th beat is held off.
  - Pulse out_ready for 1 cycle: word 1 drains and word 2 appears the next cycle with no bubble. in_ready returns high one cycle after the drain.
- Reset: assert rst low asynchronously mid-word (cnt=2) and while out_valid=1. Outputs go to 0 immediately. After release, 4 fresh beats yield a word containing only the new data.
